// File: rtl/pipe_control.sv
// rtl/pipe_control.sv - pipelined control unit with load-use, multiply-stall and branch-flush handling
module pipe_control #(
  parameter int MUL_LAT = 3,
  parameter int REG_AW  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [6:0]        Op_i,
  input  logic [6:0]        Funct7_i,
  input  logic [REG_AW-1:0] RS1addr_i,
  input  logic [REG_AW-1:0] RS2addr_i,
  input  logic [REG_AW-1:0] RDaddr_i,
  input  logic              Equal_i,
  output logic              PCWrite_o,
  output logic              IFIDWrite_o,
  output logic              Flush_o,
  output logic              Branch_o,
  output logic [1:0]        ALUOp_ex_o,
  output logic              ALUSrc_ex_o,
  output logic              Mul_ex_o,
  output logic              MemRead_mem_o,
  output logic              MemWrite_mem_o,
  output logic              RegWrite_mem_o,
  output logic              RegWrite_wb_o,
  output logic              MemtoReg_wb_o,
  output logic [REG_AW-1:0] RDaddr_ex_o,
  output logic [REG_AW-1:0] RDaddr_mem_o,
  output logic [REG_AW-1:0] RDaddr_wb_o
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);

  logic [1:0]        dec_alu_op;
  logic              dec_alu_src, dec_mul, dec_mem_read, dec_mem_write;
  logic              dec_reg_write, dec_mem_to_reg, dec_branch;

  logic [1:0]        ex_alu_op;
  logic              ex_alu_src, ex_mul, ex_mem_read, ex_mem_write;
  logic              ex_reg_write, ex_mem_to_reg;
  logic [REG_AW-1:0] ex_rd;

  logic              mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg;
  logic [REG_AW-1:0] mem_rd;

  logic              wb_reg_write, wb_mem_to_reg;
  logic [REG_AW-1:0] wb_rd;

  logic [CW-1:0]     cnt;
  logic              mul_busy, load_use, stall;

  always_comb begin
    dec_alu_op     = 2'b00;
    dec_alu_src    = 1'b0;
    dec_mul        = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_reg_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_branch     = 1'b0;
    case (Op_i)
      7'b0110011: begin
        dec_alu_op    = 2'b10;
        dec_reg_write = 1'b1;
        dec_mul       = (Funct7_i == 7'b0000001);
      end
      7'b0010011: begin
        dec_alu_op    = 2'b11;
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
      end
      7'b0000011: begin
        dec_alu_src    = 1'b1;
        dec_mem_read   = 1'b1;
        dec_reg_write  = 1'b1;
        dec_mem_to_reg = 1'b1;
      end
      7'b0100011: begin
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
      end
      7'b1100011: begin
        dec_alu_op = 2'b01;
        dec_branch = 1'b1;
      end
      default: ;
    endcase
  end

  // Multiply keeps priority; a load-use check is meaningless while EX is frozen.
  assign mul_busy = ex_mul && (cnt < CNT_LAST);
  assign load_use = !mul_busy && ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == RS1addr_i) || (ex_rd == RS2addr_i));
  assign stall    = mul_busy || load_use;

  assign PCWrite_o   = !stall;
  assign IFIDWrite_o = !stall;
  assign Flush_o     = dec_branch && Equal_i && !stall;
  assign Branch_o    = dec_branch;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_alu_op      <= 2'b00;
      ex_alu_src     <= 1'b0;
      ex_mul         <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_reg_write   <= 1'b0;
      ex_mem_to_reg  <= 1'b0;
      ex_rd          <= '0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      mem_rd         <= '0;
      wb_reg_write   <= 1'b0;
      wb_mem_to_reg  <= 1'b0;
      wb_rd          <= '0;
      cnt            <= '0;
    end else begin
      wb_reg_write  <= mem_reg_write;
      wb_mem_to_reg <= mem_mem_to_reg;
      wb_rd         <= mem_rd;
      if (mul_busy) begin
        mem_mem_read   <= 1'b0;
        mem_mem_write  <= 1'b0;
        mem_reg_write  <= 1'b0;
        mem_mem_to_reg <= 1'b0;
        mem_rd         <= '0;
        cnt            <= cnt + CW'(1);
      end else begin
        mem_mem_read   <= ex_mem_read;
        mem_mem_write  <= ex_mem_write;
        mem_reg_write  <= ex_reg_write;
        mem_mem_to_reg <= ex_mem_to_reg;
        mem_rd         <= ex_rd;
        cnt            <= '0;
        if (load_use) begin
          ex_alu_op     <= 2'b00;
          ex_alu_src    <= 1'b0;
          ex_mul        <= 1'b0;
          ex_mem_read   <= 1'b0;
          ex_mem_write  <= 1'b0;
          ex_reg_write  <= 1'b0;
          ex_mem_to_reg <= 1'b0;
          ex_rd         <= '0;
        end else begin
          ex_alu_op     <= dec_alu_op;
          ex_alu_src    <= dec_alu_src;
          ex_mul        <= dec_mul;
          ex_mem_read   <= dec_mem_read;
          ex_mem_write  <= dec_mem_write;
          ex_reg_write  <= dec_reg_write;
          ex_mem_to_reg <= dec_mem_to_reg;
          ex_rd         <= RDaddr_i;
        end
      end
    end
  end

  assign ALUOp_ex_o     = ex_alu_op;
  assign ALUSrc_ex_o    = ex_alu_src;
  assign Mul_ex_o       = ex_mul;
  assign RDaddr_ex_o    = ex_rd;
  assign MemRead_mem_o  = mem_mem_read;
  assign MemWrite_mem_o = mem_mem_write;
  assign RegWrite_mem_o = mem_reg_write;
  assign RDaddr_mem_o   = mem_rd;
  assign RegWrite_wb_o  = wb_reg_write;
  assign MemtoReg_wb_o  = wb_mem_to_reg;
  assign RDaddr_wb_o    = wb_rd;

endmodule

// File: tb/tb_pipe_control.sv
// tb/tb_pipe_control.sv - directed bench for pipe_control (MUL_LAT=3 and MUL_LAT=1 instances)
module tb_pipe_control;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_NOP = 7'b0000000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] op = '0, f7 = '0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       eq = 1'b0;

  logic       pcw_a, ifw_a, flush_a, br_a, alusrc_ex_a, mul_ex_a;
  logic       mr_mem_a, mw_mem_a, rw_mem_a, rw_wb_a, m2r_wb_a;
  logic [1:0] aluop_ex_a;
  logic [4:0] rd_ex_a, rd_mem_a, rd_wb_a;

  logic       pcw_b, ifw_b, flush_b, br_b, alusrc_ex_b, mul_ex_b;
  logic       mr_mem_b, mw_mem_b, rw_mem_b, rw_wb_b, m2r_wb_b;
  logic [1:0] aluop_ex_b;
  logic [4:0] rd_ex_b, rd_mem_b, rd_wb_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_control #(.MUL_LAT(3), .REG_AW(5)) dut_a (
    .clk_i(clk), .rst_i(rst), .Op_i(op), .Funct7_i(f7),
    .RS1addr_i(rs1), .RS2addr_i(rs2), .RDaddr_i(rd), .Equal_i(eq),
    .PCWrite_o(pcw_a), .IFIDWrite_o(ifw_a), .Flush_o(flush_a), .Branch_o(br_a),
    .ALUOp_ex_o(aluop_ex_a), .ALUSrc_ex_o(alusrc_ex_a), .Mul_ex_o(mul_ex_a),
    .MemRead_mem_o(mr_mem_a), .MemWrite_mem_o(mw_mem_a), .RegWrite_mem_o(rw_mem_a),
    .RegWrite_wb_o(rw_wb_a), .MemtoReg_wb_o(m2r_wb_a),
    .RDaddr_ex_o(rd_ex_a), .RDaddr_mem_o(rd_mem_a), .RDaddr_wb_o(rd_wb_a)
  );

  pipe_control #(.MUL_LAT(1), .REG_AW(5)) dut_b (
    .clk_i(clk), .rst_i(rst), .Op_i(op), .Funct7_i(f7),
    .RS1addr_i(rs1), .RS2addr_i(rs2), .RDaddr_i(rd), .Equal_i(eq),
    .PCWrite_o(pcw_b), .IFIDWrite_o(ifw_b), .Flush_o(flush_b), .Branch_o(br_b),
    .ALUOp_ex_o(aluop_ex_b), .ALUSrc_ex_o(alusrc_ex_b), .Mul_ex_o(mul_ex_b),
    .MemRead_mem_o(mr_mem_b), .MemWrite_mem_o(mw_mem_b), .RegWrite_mem_o(rw_mem_b),
    .RegWrite_wb_o(rw_wb_b), .MemtoReg_wb_o(m2r_wb_b),
    .RDaddr_ex_o(rd_ex_b), .RDaddr_mem_o(rd_mem_b), .RDaddr_wb_o(rd_wb_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [6:0] o, input logic [6:0] f, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] d, input logic e);
    op = o; f7 = f; rs1 = a; rs2 = b; rd = d; eq = e;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    set_id(OP_NOP, 0, 0, 0, 0, 0);
    #2;
    chk("rst_pcwrite", 32'(pcw_a), 32'd1);
    chk("rst_ifidwrite", 32'(ifw_a), 32'd1);
    chk("rst_flush", 32'(flush_a), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_rd_ex", 32'(rd_ex_a), 32'd0);
    chk("rst_rw_wb", 32'(rw_wb_a), 32'd0);

    // R-type add rd=5 propagates EX -> MEM -> WB
    set_id(OP_R, 7'd0, 5'd1, 5'd2, 5'd5, 1'b0);
    chk("add_pcwrite", 32'(pcw_a), 32'd1);
    chk("add_branch", 32'(br_a), 32'd0);
    tick();
    set_id(OP_NOP, 0, 0, 0, 0, 0);
    chk("add_aluop_ex", 32'(aluop_ex_a), 32'd2);
    chk("add_alusrc_ex", 32'(alusrc_ex_a), 32'd0);
    chk("add_rd_ex", 32'(rd_ex_a), 32'd5);
    chk("add_mul_ex", 32'(mul_ex_a), 32'd0);
    tick();
    chk("add_rw_mem", 32'(rw_mem_a), 32'd1);
    chk("add_rd_mem", 32'(rd_mem_a), 32'd5);
    tick();
    chk("add_rw_wb", 32'(rw_wb_a), 32'd1);
    chk("add_rd_wb", 32'(rd_wb_a), 32'd5);
    chk("add_m2r_wb", 32'(m2r_wb_a), 32'd0);
    chk("add_pcwrite_late", 32'(pcw_a), 32'd1);

    // lw x3 then add rs1=3: one-cycle stall with bubble in EX
    set_id(OP_LW, 7'd0, 5'd1, 5'd0, 5'd3, 1'b0);
    tick();
    set_id(OP_R, 7'd0, 5'd3, 5'd2, 5'd4, 1'b0);
    chk("lu_alusrc_ex", 32'(alusrc_ex_a), 32'd1);
    chk("lu_pcwrite", 32'(pcw_a), 32'd0);
    chk("lu_ifidwrite", 32'(ifw_a), 32'd0);
    chk("lu_flush", 32'(flush_a), 32'd0);
    tick();
    chk("lu_bubble_aluop", 32'(aluop_ex_a), 32'd0);
    chk("lu_bubble_rd", 32'(rd_ex_a), 32'd0);
    chk("lu_memread_mem", 32'(mr_mem_a), 32'd1);
    chk("lu_rd_mem", 32'(rd_mem_a), 32'd3);
    chk("lu_pcwrite_after", 32'(pcw_a), 32'd1);
    tick();
    set_id(OP_NOP, 0, 0, 0, 0, 0);
    chk("lu_add_aluop_ex", 32'(aluop_ex_a), 32'd2);
    chk("lu_add_rd_ex", 32'(rd_ex_a), 32'd4);
    chk("lu_m2r_wb", 32'(m2r_wb_a), 32'd1);
    chk("lu_rd_wb", 32'(rd_wb_a), 32'd3);

    // lw x0 never triggers the load-use stall
    set_id(OP_LW, 7'd0, 5'd1, 5'd0, 5'd0, 1'b0);
    tick();
    set_id(OP_R, 7'd0, 5'd0, 5'd0, 5'd4, 1'b0);
    chk("lu0_pcwrite", 32'(pcw_a), 32'd1);
    tick();
    set_id(OP_NOP, 0, 0, 0, 0, 0);
    chk("lu0_rd_ex", 32'(rd_ex_a), 32'd4);

    // Load-use through rs2 (store data)
    set_id(OP_LW, 7'd0, 5'd1, 5'd0, 5'd7, 1'b0);
    tick();
    set_id(OP_SW, 7'd0, 5'd2, 5'd7, 5'd0, 1'b0);
    chk("lu_rs2_pcwrite", 32'(pcw_a), 32'd0);
    tick();
    chk("lu_rs2_release", 32'(pcw_a), 32'd1);
    tick();
    set_id(OP_NOP, 0, 0, 0, 0, 0);
    chk("sw_alusrc_ex", 32'(alusrc_ex_a), 32'd1);
    tick();
    chk("sw_memwrite_mem", 32'(mw_mem_a), 32'd1);
    chk("sw_rw_mem", 32'(rw_mem_a), 32'd0);

    // beq taken / not taken
    set_id(OP_BEQ, 7'd0, 5'd1, 5'd2, 5'd0, 1'b1);
    chk("beq_t_branch", 32'(br_a), 32'd1);
    chk("beq_t_flush", 32'(flush_a), 32'd1);
    tick();
    set_id(OP_NOP, 0, 0, 0, 0, 0);
    chk("beq_t_flush_off", 32'(flush_a), 32'd0);
    chk("beq_aluop_ex", 32'(aluop_ex_a), 32'd1);
    set_id(OP_BEQ, 7'd0, 5'd1, 5'd2, 5'd0, 1'b0);
    chk("beq_nt_branch", 32'(br_a), 32'd1);
    chk("beq_nt_flush", 32'(flush_a), 32'd0);
    tick();
    set_id(OP_NOP, 0, 0, 0, 0, 0);
    tick();
    tick();

    // mul rd=6 followed by add rd=8: MUL_LAT=3 stalls 2 cycles, MUL_LAT=1 never
    set_id(OP_R, 7'b0000001, 5'd1, 5'd2, 5'd6, 1'b0);
    chk("mul_id_pcwrite", 32'(pcw_a), 32'd1);
    tick();
    set_id(OP_R, 7'd0, 5'd9, 5'd10, 5'd8, 1'b0);
    chk("mul_c1_mul_ex", 32'(mul_ex_a), 32'd1);
    chk("mul_c1_pcwrite", 32'(pcw_a), 32'd0);
    chk("mul1_c1_mul_ex", 32'(mul_ex_b), 32'd1);
    chk("mul1_c1_pcwrite", 32'(pcw_b), 32'd1);
    tick();
    chk("mul_c2_mul_ex", 32'(mul_ex_a), 32'd1);
    chk("mul_c2_pcwrite", 32'(pcw_a), 32'd0);
    chk("mul_c2_bubble_mem", 32'(rw_mem_a), 32'd0);
    chk("mul1_c2_mul_ex", 32'(mul_ex_b), 32'd0);
    chk("mul1_c2_rw_mem", 32'(rw_mem_b), 32'd1);
    chk("mul1_c2_rd_mem", 32'(rd_mem_b), 32'd6);
    tick();
    chk("mul_c3_mul_ex", 32'(mul_ex_a), 32'd1);
    chk("mul_c3_pcwrite", 32'(pcw_a), 32'd1);
    chk("mul_c3_bubble_mem", 32'(rw_mem_a), 32'd0);
    chk("mul_c3_rd_mem", 32'(rd_mem_a), 32'd0);
    tick();
    set_id(OP_NOP, 0, 0, 0, 0, 0);
    chk("mul_c4_mul_ex", 32'(mul_ex_a), 32'd0);
    chk("mul_c4_rd_ex", 32'(rd_ex_a), 32'd8);
    chk("mul_c4_rw_mem", 32'(rw_mem_a), 32'd1);
    chk("mul_c4_rd_mem", 32'(rd_mem_a), 32'd6);
    tick();
    tick();

    // mul busy in EX with a taken beq in ID: flush held off until the multiply completes
    set_id(OP_R, 7'b0000001, 5'd1, 5'd2, 5'd6, 1'b0);
    tick();
    set_id(OP_BEQ, 7'd0, 5'd1, 5'd2, 5'd0, 1'b1);
    chk("mb_c1_branch", 32'(br_a), 32'd1);
    chk("mb_c1_flush", 32'(flush_a), 32'd0);
    tick();
    chk("mb_c2_flush", 32'(flush_a), 32'd0);
    tick();
    chk("mb_c3_flush", 32'(flush_a), 32'd1);
    tick();
    set_id(OP_NOP, 0, 0, 0, 0, 0);
    chk("mb_c4_aluop_ex", 32'(aluop_ex_a), 32'd1);
    tick();
    tick();

    // Reset asserted mid-multiply clears everything asynchronously
    set_id(OP_R, 7'b0000001, 5'd1, 5'd2, 5'd6, 1'b0);
    tick();
    tick();
    chk("mr_busy_before", 32'(pcw_a), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_mul_ex", 32'(mul_ex_a), 32'd0);
    chk("mr_rd_ex", 32'(rd_ex_a), 32'd0);
    chk("mr_rw_mem", 32'(rw_mem_a), 32'd0);
    chk("mr_cnt", 32'(dut_a.cnt), 32'd0);
    chk("mr_pcwrite", 32'(pcw_a), 32'd1);
    set_id(OP_NOP, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("mr_after_pcwrite", 32'(pcw_a), 32'd1);
    chk("mr_after_mul_ex", 32'(mul_ex_a), 32'd0);
    tick();
    chk("mr_after_pcwrite2", 32'(pcw_a), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_control.md
# pipe_control

Pipelined control unit for the five-stage RISC-V core. Decodes the ID-stage opcode into a control bundle and carries it through the ID/EX, EX/MEM and MEM/WB control registers. Also detects load-use hazards, stalls for a parameterised-latency multiplier, and requests IF/ID flushes on taken branches. It replaces the single-cycle combinational control; the datapath keeps its own data pipeline registers and receives stage-aligned control from this block.

## Interface
- `MUL_LAT`, default 3: EX-stage cycles for a multiply (R-type, funct7 = 0000001). Must be ≥ 1; 1 means no stall.
- `REG_AW`, default 5: register address width.

Ports:
- `clk_i`, in, 1: clock. Rising edge.
- `rst_i`, in, 1: reset. Asynchronous, active-low.
- `Op_i`, in, 7: ID-stage opcode.
- `Funct7_i`, in, 7: ID-stage funct7.
- `RS1addr_i`, in, REG_AW: ID-stage rs1.
- `RS2addr_i`, in, REG_AW: ID-stage rs2.
- `RDaddr_i`, in, REG_AW: ID-stage rd.
- `Equal_i`, in, 1: ID-stage register compare result (rs1 == rs2).
- `PCWrite_o`, out, 1: PC update enable.
- `IFIDWrite_o`, out, 1: IF/ID register enable.
- `Flush_o`, out, 1: clear IF/ID; the branch is taken.
- `Branch_o`, out, 1: the ID instruction is beq. Combinational.
- `ALUOp_ex_o`, out, 2: EX-stage ALU operation code.
- `ALUSrc_ex_o`, out, 1: EX-stage ALU source select.
- `Mul_ex_o`, out, 1: EX-stage multiply select.
- `MemRead_mem_o`, out, 1: MEM-stage memory read enable.
- `MemWrite_mem_o`, out, 1: MEM-stage memory write enable.
- `RegWrite_mem_o`, out, 1: MEM-stage register write, for forwarding.
- `RegWrite_wb_o`, out, 1: WB-stage register write.
- `MemtoReg_wb_o`, out, 1: WB-stage write-back source select.
- `RDaddr_ex_o`, `RDaddr_mem_o`, `RDaddr_wb_o`, out, REG_AW: rd for each stage, for forwarding.

## Operation
Decode, applied to the ID-stage fields:
- 0110011 (R-type): ALUOp 10, ALUSrc 0, RegWrite 1. Mul = (Funct7_i == 0000001).
- 0010011 (I-type ALU): ALUOp 11, ALUSrc 1, RegWrite 1.
- 0000011 (lw): ALUOp 00, ALUSrc 1, MemRead 1, RegWrite 1, MemtoReg 1.
- 0100011 (sw): ALUOp 00, ALUSrc 1, MemWrite 1.
- 1100011 (beq): ALUOp 01, Branch 1.
- Any other opcode, including all-zero: every control bit 0. No X outputs.

Pipeline advance:
- Each cycle: ID/EX ← decoded bundle, EX/MEM ← ID/EX, MEM/WB ← EX/MEM. The rd fields travel with their bundle.

Hazards, in priority order:
1. Multiply busy: `Mul_ex_o` = 1 and the count is below MUL_LAT−1.
   - Hold the ID/EX register.
   - PCWrite = IFIDWrite = 0.
   - Load a bubble (all zeros) into EX/MEM.
   - Increment the count.
   - MEM/WB advances normally.
2. Load-use: `MemRead` in ID/EX = 1, `RDaddr_ex_o` ≠ 0, and `RDaddr_ex_o` equals RS1addr_i or RS2addr_i.
   - PCWrite = IFIDWrite = 0.
   - Load a bubble into ID/EX.
   - EX/MEM and MEM/WB advance.
3. Taken branch: Branch = 1 and Equal_i = 1 with no stall active.
   - Flush_o = 1.
   - The beq bundle enters ID/EX normally.
- `Flush_o` is forced to 0 in any cycle where a stall applies.

Multiply counter:
- Width is clog2(MUL_LAT), minimum 1 bit.
- Clears to 0 whenever ID/EX advances.
- After MUL_LAT EX cycles the multiply moves to MEM.
- With MUL_LAT = 1 the count never increments and nothing stalls.
- A back-to-back multiply restarts the count at 0.

Write-back protection: RegWrite with rd = 0 is carried as-is. The register file ignores x0.

## Timing
- Reset (`rst_i` = 0, asynchronous): all control and rd registers clear to 0 and the counter clears to 0. During reset PCWrite_o = IFIDWrite_o = 1 and Flush_o = 0. The stage outputs read 0 from the first cycle after reset.
- `_ex`, `_mem` and `_wb` outputs are registered. An instruction decoded in cycle N appears on `_ex` in N+1, `_mem` in N+2, `_wb` in N+3, with no stalls.
- PCWrite_o, IFIDWrite_o, Flush_o and Branch_o are combinational from the register state and the ID inputs in the same cycle.
- A load-use stall lasts exactly 1 cycle: the bubble clears the MemRead condition.
- A multiply stall lasts MUL_LAT−1 cycles.
- Reset asserted mid-stall or mid-multiply: the pipeline clears immediately. No stall persists after release.

## Test plan
- Reset, then release; drive R-type add (0110011, funct7 0) with rd 5 → `_ex` shows ALUOp 10 / ALUSrc 0 at +1 cycle; RegWrite_wb_o = 1 and RDaddr_wb_o = 5 at +3 cycles. PCWrite_o = 1 throughout.
- lw x3, then add with rs1 = 3 in ID → one cycle of PCWrite_o = IFIDWrite_o = 0 and bubble `_ex` = 0. The same sequence with lw rd = 0 → no stall.
- beq with Equal_i = 1 → Flush_o = 1 for 1 cycle and Branch_o = 1. With Equal_i = 0 → Flush_o = 0.
- MUL_LAT = 3: mul followed by add → Mul_ex_o = 1 for 3 cycles and PCWrite_o = 0 for 2 cycles. EX/MEM receives 2 bubbles; mul reaches `_mem` after 3 cycles. Repeat with MUL_LAT = 1 → no stall.
- Simultaneous hazards: mul busy in EX with a beq (Equal_i = 1) in ID → Flush_o = 0 until the multiply completes, then Flush_o = 1.
- Assert rst_i = 0 mid-multiply → all outputs clear asynchronously and the counter is 0. After release, PCWrite_o = 1 with no residual stall.
